// File: rtl/id_decode_stage.sv
// Decode stage: register file, immediate generation, load-use interlock, ID/EX register.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback into the register reads.
module id_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc4,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc4,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [6:0]      ex_opcode,
    output logic            ex_is_load,
    output logic            ex_illegal
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      rs1, rs2, rd;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic [31:0]     imm32;
    logic            illegal, wb_ok, advance, hazard;

    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign opcode = if_instr[6:0];
    assign wb_ok  = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < 6'(NREGS));

    always_ff @(posedge clk) begin
        if (wb_ok) regs[wb_addr[AW-1:0]] <= wb_data;
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < 6'(NREGS)) rs1_data = regs[rs1[AW-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < 6'(NREGS)) rs2_data = regs[rs2[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wb_ok && wb_addr == rs1) rs1_data = wb_data;
        if (wb_ok && wb_addr == rs2) rs2_data = wb_data;
`endif
    end

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            7'b0100011:
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            7'b1100011:
                imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {if_instr[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            7'b0110011, 7'b1110011:
                imm32 = '0;
            default:
                illegal = 1'b1;
        endcase
        imm = XLEN'($signed(imm32));
    end

    assign advance  = !ex_valid || ex_ready;
    assign hazard   = if_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
                      (ex_rd == rs1 || ex_rd == rs2);
    assign id_ready = rst || flush || (advance && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc4      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_opcode   <= '0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!advance) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            // Bubble; the load-dependent instruction stays in IF/ID.
            ex_valid <= 1'b0;
        end else begin
            ex_valid    <= if_valid;
            ex_pc4      <= if_pc4;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_funct3   <= if_instr[14:12];
            ex_funct7   <= if_instr[31:25];
            ex_opcode   <= opcode;
            ex_is_load  <= (opcode == 7'b0000011);
            ex_illegal  <= illegal;
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vector table plus hazard/stall/flush/reset sequences.
module tb_id_decode_stage;

    logic        clk, rst, if_valid, id_ready, flush, ex_ready, wb_we;
    logic [31:0] if_instr, if_pc4, wb_data;
    logic [4:0]  wb_addr;
    logic        ex_valid, ex_is_load, ex_illegal;
    logic [31:0] ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7, ex_opcode;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rf [32];

    id_decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc4(if_pc4), .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
        .ex_pc4(ex_pc4), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_opcode(ex_opcode),
        .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
        logic        is_load;
    } vec_t;

    localparam logic [31:0] LW7   = 32'h0000A383;
    localparam logic [31:0] ADD8  = 32'h00238433;
    localparam logic [31:0] ADDI6 = 32'hFFF28313;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
        if (a != 5'd0) model_rf[a] = d;
    endtask

    vec_t vt [10];

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc4 = '0;
        flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_ex_imm", ex_imm, 32'd0);
        chk("reset_ex_pc4", ex_pc4, 32'd0);
        chk("reset_id_ready", {31'b0, id_ready}, 32'd1);

        for (int i = 1; i < 32; i++) wb_write(5'(i), 32'hC000_0000 | i);
        wb_write(5'd1, 32'h0000_0100);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd5, 32'h0000_1234);
        wb_write(5'd9, 32'h5555_0000);
        wb_write(5'd0, 32'hFFFF_FFFF);

        vt[0] = '{32'hFFF28313, 32'hFFFF_FFFF, 5'd6,  5'd5,  5'd31, 1'b0, 1'b0};
        vt[1] = '{32'h0020A423, 32'h0000_0008, 5'd8,  5'd1,  5'd2,  1'b0, 1'b0};
        vt[2] = '{32'hFE208EE3, 32'hFFFF_FFFC, 5'd29, 5'd1,  5'd2,  1'b0, 1'b0};
        vt[3] = '{32'h123451B7, 32'h1234_5000, 5'd3,  5'd8,  5'd3,  1'b0, 1'b0};
        vt[4] = '{32'h0040A503, 32'h0000_0004, 5'd10, 5'd1,  5'd4,  1'b0, 1'b1};
        vt[5] = '{32'h008000EF, 32'h0000_0008, 5'd1,  5'd0,  5'd8,  1'b0, 1'b0};
        vt[6] = '{32'hFFDFF06F, 32'hFFFF_FFFC, 5'd0,  5'd31, 5'd29, 1'b0, 1'b0};
        vt[7] = '{32'hFFFFF217, 32'hFFFF_F000, 5'd4,  5'd31, 5'd31, 1'b0, 1'b0};
        vt[8] = '{32'h0000007F, 32'h0000_0000, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
        vt[9] = '{32'hFF0100E7, 32'hFFFF_FFF0, 5'd1,  5'd2,  5'd16, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            if_valid = 1'b1;
            if_instr = vt[i].instr;
            if_pc4   = 32'h1000 + 32'(4 * i);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'd1);
            chk($sformatf("v%0d_imm", i), ex_imm, vt[i].imm);
            chk($sformatf("v%0d_rd", i), {27'b0, ex_rd}, {27'b0, vt[i].rd});
            chk($sformatf("v%0d_rs1", i), {27'b0, ex_rs1}, {27'b0, vt[i].rs1});
            chk($sformatf("v%0d_rs1_data", i), ex_rs1_data, model_rf[vt[i].rs1]);
            chk($sformatf("v%0d_rs2_data", i), ex_rs2_data, model_rf[vt[i].rs2]);
            chk($sformatf("v%0d_illegal", i), {31'b0, ex_illegal}, {31'b0, vt[i].illegal});
            chk($sformatf("v%0d_is_load", i), {31'b0, ex_is_load}, {31'b0, vt[i].is_load});
            chk($sformatf("v%0d_pc4", i), ex_pc4, 32'h1000 + 32'(4 * i));
        end
        if_valid = 1'b0;
        tick();
        chk("idle_ex_valid", {31'b0, ex_valid}, 32'd0);

        // load-use: exactly one bubble
        if_valid = 1'b1; if_instr = LW7; if_pc4 = 32'h2004;
        tick();
        chk("lu_load_issued", {31'b0, ex_is_load}, 32'd1);
        if_instr = ADD8; if_pc4 = 32'h2008;
        #1;
        chk("lu_id_ready_low", {31'b0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        chk("lu_id_ready_back", {31'b0, id_ready}, 32'd1);
        tick();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_rs1", {27'b0, ex_rs1}, 32'd7);
        chk("lu_add_rs1_data", ex_rs1_data, model_rf[7]);
        if_valid = 1'b0;
        tick();

        // back-pressure for three cycles
        if_valid = 1'b1; if_instr = ADDI6; if_pc4 = 32'h3004;
        tick();
        ex_ready = 1'b0; if_instr = ADD8; if_pc4 = 32'h3008;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d_id_ready", c), {31'b0, id_ready}, 32'd0);
            tick();
            chk($sformatf("st%0d_valid", c), {31'b0, ex_valid}, 32'd1);
            chk($sformatf("st%0d_rd", c), {27'b0, ex_rd}, 32'd6);
            chk($sformatf("st%0d_pc4", c), ex_pc4, 32'h3004);
            chk($sformatf("st%0d_rs1_data", c), ex_rs1_data, 32'h1234);
        end
        ex_ready = 1'b1;
        tick();
        chk("st_release_rd", {27'b0, ex_rd}, 32'd8);
        chk("st_release_pc4", ex_pc4, 32'h3008);
        if_valid = 1'b0;
        tick();

        // same-cycle writeback to x9
        if_valid = 1'b1; if_instr = 32'h00048593; if_pc4 = 32'h4004;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_A5A5;
        tick();
        wb_we = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("byp_same_cycle", ex_rs1_data, 32'hA5A5_A5A5);
`else
        chk("byp_same_cycle", ex_rs1_data, 32'h5555_0000);
`endif
        model_rf[9] = 32'hA5A5_A5A5;
        tick();
        chk("byp_next_cycle", ex_rs1_data, 32'hA5A5_A5A5);
        if_instr = 32'h00000613;
        tick();
        chk("x0_reads_zero", ex_rs1_data, 32'd0);
        if_valid = 1'b0;
        tick();

        // flush during stall with hazard pending
        if_valid = 1'b1; if_instr = LW7; if_pc4 = 32'h5004;
        tick();
        ex_ready = 1'b0; if_instr = ADD8; flush = 1'b1;
        #1;
        chk("fl_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
        flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
        tick();

        // reset in the middle of a stall
        if_valid = 1'b1; if_instr = LW7; if_pc4 = 32'h6004;
        tick();
        ex_ready = 1'b0; if_instr = ADD8;
        #1;
        chk("rs_stalled", {31'b0, id_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rs_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("rs_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rs_ex_rd", {27'b0, ex_rd}, 32'd0);
        chk("rs_ex_pc4", ex_pc4, 32'd0);
        chk("rs_ex_rs1_data", ex_rs1_data, 32'd0);
        chk("rs_ex_is_load", {31'b0, ex_is_load}, 32'd0);
        chk("rs_ex_opcode", {25'b0, ex_opcode}, 32'd0);
        rst = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
